// File: rtl/clock_phase_gen.sv
// Two-phase timing generator: phi1/phi2 levels, step_a/step_b enables, 8-subcycle sequencer with SYNC.
// Latency: every output is a registered decode of the (subcycle, tick) counter, one sysclk behind it.
// Backpressure: none; stop freezes the counter at A1/t0 only at the X3 boundary, released by stop low.
module clock_phase_gen #(
  parameter int unsigned SUB_TICKS = 8,
  parameter int unsigned PHI_W     = 2
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       stop,
  output logic       phi1,
  output logic       phi2,
  output logic       step_a,
  output logic       step_b,
  output logic       sync_n,
  output logic [7:0] subcycle,
  output logic       halted
);

  localparam int unsigned TW = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
  localparam int unsigned H  = SUB_TICKS / 2;

  // Tick decode points; phi1 occupies [0, PHI_W), phi2 occupies [H, H+PHI_W).
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] T_LAST     = TW'(SUB_TICKS - 1);
  localparam logic [TW-1:0] T_PHI1_END = TW'(PHI_W);
  localparam logic [TW-1:0] T_STEP_A   = TW'(PHI_W - 1);
  localparam logic [TW-1:0] T_PHI2_BEG = TW'(H);
  localparam logic [TW-1:0] T_PHI2_END = TW'(H + PHI_W);
  localparam logic [TW-1:0] T_STEP_B   = TW'(H + PHI_W - 1);

  localparam logic [2:0] S_X3 = 3'd7;

  logic [TW-1:0] t_q, t_d;
  logic [2:0]    s_q, s_d;
  logic          halt_q, halt_d;

  logic       phi1_q, phi1_d;
  logic       phi2_q, phi2_d;
  logic       step_a_q, step_a_d;
  logic       step_b_q, step_b_d;
  logic       sync_n_q, sync_n_d;
  logic [7:0] subcycle_q, subcycle_d;
  logic       halted_q, halted_d;

  // Counter advance; stop is only looked at on the final tick of X3, and a halt
  // parks the counter at A1/t0 so counting restarts with a full phi1.
  always_comb begin
    t_d    = t_q;
    s_d    = s_q;
    halt_d = halt_q;
    if (halt_q) begin
      t_d = '0;
      s_d = 3'd0;
      if (!stop) begin
        halt_d = 1'b0;
      end
    end else if (t_q == T_LAST) begin
      t_d = '0;
      s_d = s_q + 3'd1;
      if ((s_q == S_X3) && stop) begin
        s_d    = 3'd0;
        halt_d = 1'b1;
      end
    end else begin
      t_d = t_q + T_ONE;
    end
  end

  // Decode of the current counter state; a halt forces every phase output idle.
  always_comb begin
    phi1_d     = 1'b0;
    phi2_d     = 1'b0;
    step_a_d   = 1'b0;
    step_b_d   = 1'b0;
    sync_n_d   = 1'b1;
    subcycle_d = 8'h01;
    halted_d   = halt_q;
    if (!halt_q) begin
      phi1_d     = (t_q < T_PHI1_END);
      phi2_d     = (t_q >= T_PHI2_BEG) && (t_q < T_PHI2_END);
      step_a_d   = (t_q == T_STEP_A);
      step_b_d   = (t_q == T_STEP_B);
      sync_n_d   = (s_q != S_X3);
      subcycle_d = 8'h01 << s_q;
    end
  end

  // Counter and halt state registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      t_q    <= '0;
      s_q    <= 3'd0;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      s_q    <= s_d;
      halt_q <= halt_d;
    end
  end

  // Output registers; reset drives them idle immediately, without a clock.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
      step_a_q   <= 1'b0;
      step_b_q   <= 1'b0;
      sync_n_q   <= 1'b1;
      subcycle_q <= 8'h01;
      halted_q   <= 1'b0;
    end else begin
      phi1_q     <= phi1_d;
      phi2_q     <= phi2_d;
      step_a_q   <= step_a_d;
      step_b_q   <= step_b_d;
      sync_n_q   <= sync_n_d;
      subcycle_q <= subcycle_d;
      halted_q   <= halted_d;
    end
  end

  assign phi1     = phi1_q;
  assign phi2     = phi2_q;
  assign step_a   = step_a_q;
  assign step_b   = step_b_q;
  assign sync_n   = sync_n_q;
  assign subcycle = subcycle_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: default instance plus a SUB_TICKS=4/PHI_W=1 instance.
// Inputs change and outputs are sampled on the falling sysclk edge.
// A two-phase toggle stage driven by step_a/step_b checks the enables end to end.
module tb_clock_phase_gen;

  logic       sysclk  = 1'b0;
  logic       reset_n = 1'b0;
  logic       stop    = 1'b0;
  logic       stop4   = 1'b0;

  logic       phi1, phi2, step_a, step_b, sync_n, halted;
  logic [7:0] subcycle;
  logic       phi1_4, phi2_4, step_a_4, step_b_4, sync_n_4, halted_4;
  logic [7:0] subcycle_4;

  int errors = 0;
  int checks = 0;

  // Two-phase toggle stage: master loads !q on step_a, q takes master on step_b.
  logic m_cnt, q_cnt;

  clock_phase_gen dut (
    .sysclk(sysclk), .reset_n(reset_n), .stop(stop),
    .phi1(phi1), .phi2(phi2), .step_a(step_a), .step_b(step_b),
    .sync_n(sync_n), .subcycle(subcycle), .halted(halted)
  );

  clock_phase_gen #(.SUB_TICKS(4), .PHI_W(1)) dut4 (
    .sysclk(sysclk), .reset_n(reset_n), .stop(stop4),
    .phi1(phi1_4), .phi2(phi2_4), .step_a(step_a_4), .step_b(step_b_4),
    .sync_n(sync_n_4), .subcycle(subcycle_4), .halted(halted_4)
  );

  initial forever #5 sysclk = ~sysclk;

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 1'b0;
      q_cnt <= 1'b0;
    end else begin
      if (step_a) m_cnt <= ~q_cnt;
      if (step_b) q_cnt <= m_cnt;
    end
  end

  // Expects to be called on a falling edge with reset_n low; releases reset and
  // checks the first eight outputs of A1.
  task automatic check_start_sequence(input string tag);
    logic [7:0] e_phi1, e_phi2, e_sta, e_stb;
    e_phi1 = 8'b0000_0011;
    e_phi2 = 8'b0011_0000;
    e_sta  = 8'b0000_0010;
    e_stb  = 8'b0010_0000;
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge sysclk);
      checks += 4;
      if (phi1 !== e_phi1[n]) begin
        errors++;
        $display("FAIL %s phi1 cycle %0d: got %b want %b", tag, n + 1, phi1, e_phi1[n]);
      end
      if (phi2 !== e_phi2[n]) begin
        errors++;
        $display("FAIL %s phi2 cycle %0d: got %b want %b", tag, n + 1, phi2, e_phi2[n]);
      end
      if (step_a !== e_sta[n]) begin
        errors++;
        $display("FAIL %s step_a cycle %0d: got %b want %b", tag, n + 1, step_a, e_sta[n]);
      end
      if (step_b !== e_stb[n]) begin
        errors++;
        $display("FAIL %s step_b cycle %0d: got %b want %b", tag, n + 1, step_b, e_stb[n]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    checks++;
    if ({phi1, phi2, step_a, step_b, sync_n, subcycle, halted} !== {5'b00001, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got phi1=%b phi2=%b sa=%b sb=%b sync_n=%b sub=%h halted=%b want 0 0 0 0 1 01 0",
               phi1, phi2, step_a, step_b, sync_n, subcycle, halted);
    end
    check_start_sequence("release");
  endtask

  task automatic test_free_run();
    int s, t, s4, t4, na, nb, tog, tog64;
    logic [7:0] one8, e_sub, e_sub4;
    logic qp;
    one8 = 8'h01;
    na = 0; nb = 0; tog = 0; tog64 = 0;
    reset_n = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b1;
    qp = q_cnt;
    for (int n = 1; n <= 128; n++) begin
      @(negedge sysclk);
      s = ((n - 1) / 8) % 8;
      t = (n - 1) % 8;
      e_sub = one8 << s;
      checks += 3;
      if (subcycle !== e_sub) begin
        errors++;
        $display("FAIL run_subcycle cycle %0d: got %h want %h", n, subcycle, e_sub);
      end
      if (sync_n !== (s != 7)) begin
        errors++;
        $display("FAIL run_sync_n cycle %0d: got %b want %b", n, sync_n, (s != 7));
      end
      if ({step_a, step_b} !== {(t == 1), (t == 5)}) begin
        errors++;
        $display("FAIL run_steps cycle %0d: got a=%b b=%b want a=%b b=%b", n, step_a, step_b, (t == 1), (t == 5));
      end
      if (step_a === 1'b1) na++;
      if (step_b === 1'b1) nb++;
      if (q_cnt !== qp) begin
        tog++;
        if (n <= 64) tog64++;
      end
      qp = q_cnt;
      // Narrow instance: 4 ticks per subcycle, 32 per instruction cycle.
      s4 = ((n - 1) / 4) % 8;
      t4 = (n - 1) % 4;
      e_sub4 = one8 << s4;
      checks += 3;
      if ({phi1_4, phi2_4, step_a_4, step_b_4} !== {(t4 == 0), (t4 == 2), (t4 == 0), (t4 == 2)}) begin
        errors++;
        $display("FAIL st4_phases cycle %0d: got phi1=%b phi2=%b sa=%b sb=%b want t=%0d",
                 n, phi1_4, phi2_4, step_a_4, step_b_4, t4);
      end
      if (subcycle_4 !== e_sub4) begin
        errors++;
        $display("FAIL st4_subcycle cycle %0d: got %h want %h", n, subcycle_4, e_sub4);
      end
      if (sync_n_4 !== (s4 != 7)) begin
        errors++;
        $display("FAIL st4_sync_n cycle %0d: got %b want %b", n, sync_n_4, (s4 != 7));
      end
    end
    checks += 4;
    if (na != 16) begin
      errors++;
      $display("FAIL step_a_count: got %0d want 16", na);
    end
    if (nb != 16) begin
      errors++;
      $display("FAIL step_b_count: got %0d want 16", nb);
    end
    if (tog64 != 8) begin
      errors++;
      $display("FAIL counter_toggles_64: got %0d want 8", tog64);
    end
    if (tog != 16) begin
      errors++;
      $display("FAIL counter_toggles_128: got %0d want 16", tog);
    end
  endtask

  task automatic test_stop();
    int budget, x3, bad, seen_halt;
    // Raise stop once M1 is visible and hold it.
    budget = 0;
    while (subcycle !== 8'h08 && budget < 80) begin
      @(negedge sysclk);
      budget++;
    end
    checks++;
    if (subcycle !== 8'h08) begin
      errors++;
      $display("FAIL stop_wait_m1: got %h want 08", subcycle);
    end
    stop = 1'b1;
    budget = 0;
    while (subcycle !== 8'h80 && budget < 80) begin
      @(negedge sysclk);
      budget++;
    end
    x3 = 0;
    while (subcycle === 8'h80 && x3 < 20) begin
      x3++;
      @(negedge sysclk);
    end
    checks += 2;
    if (x3 != 8) begin
      errors++;
      $display("FAIL stop_x3_len: got %0d want 8", x3);
    end
    if ({halted, subcycle, sync_n, phi1} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL halt_entry: got halted=%b sub=%h sync_n=%b phi1=%b want 1 01 1 0",
               halted, subcycle, sync_n, phi1);
    end
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge sysclk);
      if ({phi1, phi2, step_a, step_b, halted, sync_n, subcycle} !== {6'b000011, 8'h01}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
    end
    // Drop stop: halt clears on this edge, phi1 appears on the following one.
    stop = 1'b0;
    @(negedge sysclk);
    checks++;
    if ({halted, phi1} !== 2'b10) begin
      errors++;
      $display("FAIL halt_clear_edge: got halted=%b phi1=%b want 1 0", halted, phi1);
    end
    @(negedge sysclk);
    checks++;
    if ({halted, phi1, step_a, subcycle} !== {3'b010, 8'h01}) begin
      errors++;
      $display("FAIL resume_first: got halted=%b phi1=%b sa=%b sub=%h want 0 1 0 01",
               halted, phi1, step_a, subcycle);
    end
    @(negedge sysclk);
    checks++;
    if ({phi1, step_a} !== 2'b11) begin
      errors++;
      $display("FAIL resume_second: got phi1=%b sa=%b want 1 1", phi1, step_a);
    end
    @(negedge sysclk);
    checks++;
    if (phi1 !== 1'b0) begin
      errors++;
      $display("FAIL resume_third: got phi1=%b want 0", phi1);
    end
    // A stop pulse confined to A2 must not halt at the next X3 boundary.
    budget = 0;
    while (subcycle !== 8'h02 && budget < 80) begin
      @(negedge sysclk);
      budget++;
    end
    stop = 1'b1;
    budget = 0;
    while (subcycle === 8'h02 && budget < 20) begin
      @(negedge sysclk);
      budget++;
    end
    stop = 1'b0;
    seen_halt = 0;
    x3 = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge sysclk);
      if (halted !== 1'b0) seen_halt++;
      if (sync_n === 1'b0) x3++;
    end
    checks += 2;
    if (seen_halt != 0) begin
      errors++;
      $display("FAIL a2_pulse_no_halt: got %0d halted cycles want 0", seen_halt);
    end
    if (x3 < 8) begin
      errors++;
      $display("FAIL a2_pulse_x3_seen: got %0d sync cycles want at least 8", x3);
    end
  endtask

  task automatic test_reset_mid();
    int budget, bad;
    budget = 0;
    while (subcycle !== 8'h10 && budget < 80) begin
      @(negedge sysclk);
      budget++;
    end
    // Counter now at M2 t=1; two more edges bring it to t=3.
    @(negedge sysclk);
    @(negedge sysclk);
    checks++;
    if (subcycle !== 8'h10) begin
      errors++;
      $display("FAIL mid_pre: got sub=%h want 10", subcycle);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({phi1, phi2, step_a, step_b, sync_n, subcycle, halted} !== {5'b00001, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_async: got phi1=%b phi2=%b sa=%b sb=%b sync_n=%b sub=%h halted=%b want 0 0 0 0 1 01 0",
               phi1, phi2, step_a, step_b, sync_n, subcycle, halted);
    end
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge sysclk);
      if ({phi1, phi2, step_a, step_b, sync_n, subcycle} !== {5'b00001, 8'h01}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_hold: got %0d bad cycles want 0", bad);
    end
    check_start_sequence("mid_release");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
